// File: rtl/uart_tx_fifo_if.sv
// Bus-side write port and status of the buffered UART transmitter.
// The CPU bus is the master and the transmitter is the slave.
interface uart_tx_fifo_if #(
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             clr_overrun;
  logic             overrun;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;

  modport master (
    output in_valid, in_data, clr_overrun,
    input  in_ready, overrun, fifo_count, busy
  );

  modport slave (
    input  in_valid, in_data, clr_overrun,
    output in_ready, overrun, fifo_count, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bus writes fill a byte FIFO that a serializer
// drains LSB-first onto uart_tx at CLKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus,
  output logic           uart_tx
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;
  logic             in_ready_q, overrun_q, busy_q;
  logic [1:0]       state, state_n;
  logic [15:0]      baud, baud_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shifter, shift_n;
  logic             tx_q, tx_n;
  logic             wr, pop, fifo_nonempty, bit_done;

  assign fifo_nonempty = (count != '0);
  assign bit_done      = (baud == BAUD_LAST);
  assign wr            = bus.in_valid & in_ready_q;

  assign count_n = count + {{(CNT_W-1){1'b0}}, wr} - {{(CNT_W-1){1'b0}}, pop};

  // Popping only looks at the registered count, so a byte written into an
  // empty FIFO leaves on the following edge; tx_n is the next line value.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shifter;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
          baud_n  = '0;
        end
      end
      START: begin
        if (bit_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shifter[0];
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shifter[7:1]};
            tx_n    = shifter[1];
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_n = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.in_data;
  end

  // in_ready and busy are registered from next-state values so they always
  // agree with the fifo_count and state registers they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      tx_q       <= 1'b1;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_ready_q <= 1'b1;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_n;
      shifter    <= shift_n;
      tx_q       <= tx_n;
      count      <= count_n;
      in_ready_q <= (count_n != FULL_CNT);
      busy_q     <= (state_n != IDLE) | (count_n != '0);
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (bus.in_valid & ~in_ready_q) overrun_q <= 1'b1;
      else if (bus.clr_overrun)       overrun_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.fifo_count = count;
  assign bus.busy       = busy_q;
  assign uart_tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model checked
// every cycle, plus a frame table and directed corner-case sequences.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;

  uart_tx_fifo_if #(.CNT_W(CNT_W)) bus();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_line;
  } frame_vec_t;

  frame_vec_t vecs [4];

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes plus the position inside the frame on the line.
  logic [7:0] mq [$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_frame;
  bit         m_ov;
  logic       line_log [$];

  function automatic void model_reset();
    mq.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_frame  = 8'h00;
    m_ov     = 1'b0;
  endfunction

  function automatic logic model_line();
    int bi;
    if (!m_active) return 1'b1;
    bi = m_t / CPB;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return m_frame[bi-1];
  endfunction

  function automatic void model_edge();
    bit accept;
    if (rst) begin
      model_reset();
      return;
    end
    accept = bus.in_valid && (mq.size() != DEPTH);
    if (bus.in_valid && mq.size() == DEPTH) m_ov = 1'b1;
    else if (bus.clr_overrun)               m_ov = 1'b0;
    if (mq.size() != 0 && (!m_active || m_t == FRAME - 1)) begin
      m_frame  = mq.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t == FRAME) begin
        m_active = 1'b0;
        m_t      = 0;
      end
    end
    if (accept) mq.push_back(bus.in_data);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("uart_tx",    32'(uart_tx),        32'(model_line()));
    check("in_ready",   32'(bus.in_ready),   32'(mq.size() != DEPTH));
    check("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    check("busy",       32'(bus.busy),       32'(m_active || mq.size() != 0));
    check("overrun",    32'(bus.overrun),    32'(m_ov));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.clr_overrun = c;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    line_log.push_back(uart_tx);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        v;
    logic [9:0]  line, l0, l1;
    logic [7:0]  rx, exp_byte;
    int          base, zeros, idx;
    bit          found;

    // Line bit i of each frame: start, data LSB first, stop.
    vecs[0] = '{data: 8'hA5, exp_line: 10'h34A};
    vecs[1] = '{data: 8'h00, exp_line: 10'h200};
    vecs[2] = '{data: 8'hFF, exp_line: 10'h3FE};
    vecs[3] = '{data: 8'h3C, exp_line: 10'h278};

    applyStimulus(1'b0, 8'h00, 1'b0);
    model_reset();
    @(negedge clk);

    $display("[TB] reset with toggling inputs");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), 8'($urandom), 1'($urandom));
      step();
    end
    check("rst_uart_tx",    32'(uart_tx),        32'd1);
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("rst_overrun",    32'(bus.overrun),    32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    step();
    step();

    $display("[TB] single-frame table");
    for (int n = 0; n < 4; n++) begin
      line = vecs[n].exp_line;
      applyStimulus(1'b1, vecs[n].data, 1'b0);
      step();
      applyStimulus(1'b0, 8'h00, 1'b0);
      check("pre_fall_tx", 32'(uart_tx), 32'd1);
      for (int t = 0; t < FRAME; t++) begin
        step();
        check("frame_bit", 32'(uart_tx), 32'(line[t/CPB]));
      end
      step();
      check("busy_after_stop", 32'(bus.busy), 32'd0);
    end

    $display("[TB] back-to-back frames");
    l0 = 10'h200;
    l1 = 10'h3FE;
    applyStimulus(1'b1, 8'h00, 1'b0);
    step();
    applyStimulus(1'b1, 8'hFF, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0);
    check("b2b_bit", 32'(uart_tx), 32'(l0[0]));
    for (int k = 1; k < 2 * FRAME; k++) begin
      step();
      if (k < FRAME) check("b2b_bit", 32'(uart_tx), 32'(l0[k/CPB]));
      else           check("b2b_bit", 32'(uart_tx), 32'(l1[(k-FRAME)/CPB]));
    end
    step();
    check("b2b_idle", 32'(bus.busy), 32'd0);

    $display("[TB] full FIFO and overrun");
    base = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h11 + i), 1'b0);
      if (i == 5) check("full_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      if (i == 0) base = line_log.size();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    check("overrun_set", 32'(bus.overrun), 32'd1);
    check("full_count",  32'(bus.fifo_count), 32'd4);
    for (int i = 0; i < 5 * FRAME; i++) step();
    for (int j = 0; j < 5; j++) begin
      for (int b = 0; b < 8; b++) begin
        idx   = base + j * FRAME + (b + 1) * CPB + CPB / 2;
        rx[b] = line_log[idx];
      end
      exp_byte = 8'(8'h11 + j);
      check("rx_byte", 32'(rx), 32'(exp_byte));
    end
    check("overrun_sticky", 32'(bus.overrun), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0);
    check("overrun_cleared", 32'(bus.overrun), 32'd0);

    $display("[TB] write at full on pop edge");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h21 + i), 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (m_active && m_t == FRAME - 1) found = 1'b1;
      else step();
    end
    check("pop_edge_found", 32'(found), 32'd1);
    check("pre_pop_count", 32'(bus.fifo_count), 32'd4);
    applyStimulus(1'b1, 8'h77, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0);
    check("pop_edge_overrun", 32'(bus.overrun),    32'd1);
    check("pop_edge_count",   32'(bus.fifo_count), 32'd3);
    check("pop_edge_start",   32'(uart_tx),        32'd0);
    for (int i = 0; i < 4 * FRAME + 5; i++) step();
    applyStimulus(1'b0, 8'h00, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h31 + i), 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (m_active && m_t == 4 * CPB + 1) found = 1'b1;
      else step();
    end
    check("data_bit3_found", 32'(found), 32'd1);
    check("queued_before_rst", 32'(bus.fifo_count), 32'd2);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_tx",    32'(uart_tx),        32'd1);
    check("rst_mid_count", 32'(bus.fifo_count), 32'd0);
    check("rst_mid_busy",  32'(bus.busy),       32'd0);
    step();
    rst   = 1'b0;
    zeros = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (uart_tx !== 1'b1) zeros++;
    end
    check("no_frame_after_rst", 32'(zeros), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if (((i / 500) % 2) == 1) v = ($urandom_range(0, 3) == 0);
      else                      v = ($urandom_range(0, 39) == 0);
      applyStimulus(v, 8'($urandom), $urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 699) == 0);
      step();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
